cpi_sync_gen: RTL and testbench

//  Parametrised CPI timing generator on the pixel clock domain.

---
 rtl/cpi_sync_gen.sv | 192 +++++++++++++++++++
 tb/tb_cpi_sync_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cpi_sync_gen.sv
// rtl/cpi_sync_gen.sv - CPI VSYNC/HSYNC timing generator driven by frame strobes and line valid
// Pixel data rides a DLY-deep pipeline alongside the gated line-valid so it stays aligned with HSYNC.
module cpi_sync_gen #(
  parameter int   DATA_W   = 10,
  parameter int   CNT_W    = 12,
  parameter int   VS_WIDTH = 8,
  parameter int   VBP      = 16,
  parameter int   DLY      = 2,
  parameter logic VS_POL   = 1'b1,
  parameter logic HS_POL   = 1'b1
) (
  input  logic              pixel_clk_i,
  input  logic              pixel_rstn_i,
  input  logic              fs_i,
  input  logic              fe_i,
  input  logic              lv_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vsync_o,
  output logic              hsync_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  pix_cnt_o,
  output logic [CNT_W-1:0]  line_cnt_o,
  output logic              frame_done_o,
  output logic              err_fs_o,
  output logic              err_fe_o
);

  localparam int TMAX = (VS_WIDTH > VBP) ? VS_WIDTH : VBP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam logic [TW-1:0] VS_LAST  = TW'(VS_WIDTH - 1);
  localparam logic [TW-1:0] VBP_LAST = (VBP > 0) ? TW'(VBP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VSYNC  = 2'd1,
    S_VBP    = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [TW-1:0]     tcnt;
  logic [CNT_W-1:0]  pcnt;
  logic [CNT_W-1:0]  lcnt;
  logic              line_open;

  logic              active;
  logic              lv_g;
  logic              frame_end;
  logic              restart;
  logic              line_end;
  logic [CNT_W-1:0]  pix_total;
  logic [CNT_W-1:0]  line_total;

  logic [DLY-1:0]    lv_pipe;
  logic [DATA_W-1:0] d_pipe [DLY];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // State register and phase timer; any fs_i restarts the VSYNC phase timing.
  always_ff @(posedge pixel_clk_i or negedge pixel_rstn_i) begin
    if (!pixel_rstn_i) begin
      state <= S_IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      if (fs_i || (state_nx != state)) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    if (fs_i) begin
      state_nx = S_VSYNC;
    end else begin
      case (state)
        S_IDLE:   state_nx = S_IDLE;
        S_VSYNC: begin
          if (tcnt == VS_LAST) begin
            state_nx = (VBP == 0) ? S_ACTIVE : S_VBP;
          end
        end
        S_VBP: begin
          if (tcnt == VBP_LAST) begin
            state_nx = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (fe_i) begin
            state_nx = S_IDLE;
          end
        end
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    vsync_o = ~VS_POL;
    if (state == S_VSYNC) begin
      vsync_o = VS_POL;
    end
  end

  // A line closes on the gated lv falling edge, or at frame end if it is still open
  // (then the fe_i cycle itself counts as a pixel when lv is high).
  always_comb begin
    active     = (state == S_ACTIVE);
    lv_g       = lv_i & active;
    frame_end  = active & fe_i;
    restart    = fs_i & (state != S_IDLE) & ~frame_end;
    line_end   = frame_end ? (line_open | lv_g) : (line_open & ~lv_g);
    pix_total  = lv_g ? sat_inc(pcnt) : pcnt;
    line_total = line_end ? sat_inc(lcnt) : lcnt;
  end

  always_ff @(posedge pixel_clk_i or negedge pixel_rstn_i) begin
    if (!pixel_rstn_i) begin
      pcnt       <= '0;
      lcnt       <= '0;
      line_open  <= 1'b0;
      pix_cnt_o  <= '0;
      line_cnt_o <= '0;
    end else if (restart) begin
      pcnt      <= '0;
      lcnt      <= '0;
      line_open <= 1'b0;
    end else if (frame_end) begin
      if (line_end) begin
        pix_cnt_o <= pix_total;
      end
      line_cnt_o <= line_total;
      pcnt       <= '0;
      lcnt       <= '0;
      line_open  <= 1'b0;
    end else if (line_end) begin
      pix_cnt_o <= pix_total;
      lcnt      <= line_total;
      pcnt      <= '0;
      line_open <= 1'b0;
    end else if (lv_g) begin
      pcnt      <= sat_inc(pcnt);
      line_open <= 1'b1;
    end
  end

  always_ff @(posedge pixel_clk_i or negedge pixel_rstn_i) begin
    if (!pixel_rstn_i) begin
      frame_done_o <= 1'b0;
      err_fs_o     <= 1'b0;
      err_fe_o     <= 1'b0;
    end else begin
      frame_done_o <= frame_end;
      err_fs_o     <= restart;
      err_fe_o     <= fe_i & ((state == S_IDLE) | (active & lv_i));
    end
  end

  // Data is zeroed on entry so the output naturally holds 0 outside valid pixels.
  always_ff @(posedge pixel_clk_i or negedge pixel_rstn_i) begin
    if (!pixel_rstn_i) begin
      lv_pipe <= '0;
      for (int i = 0; i < DLY; i++) begin
        d_pipe[i] <= '0;
      end
    end else begin
      lv_pipe[0] <= lv_g;
      d_pipe[0]  <= lv_g ? data_i : '0;
      for (int i = 1; i < DLY; i++) begin
        lv_pipe[i] <= lv_pipe[i-1];
        d_pipe[i]  <= d_pipe[i-1];
      end
    end
  end

  always_comb begin
    hsync_o = ~HS_POL;
    data_o  = '0;
    if (lv_pipe[DLY-1]) begin
      hsync_o = HS_POL;
      data_o  = d_pipe[DLY-1];
    end
  end

endmodule

// File: tb/tb_cpi_sync_gen.sv
// tb/tb_cpi_sync_gen.sv - directed checks of cpi_sync_gen framing, pipeline, counters and errors
module tb_cpi_sync_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fs, fe, lv;
  logic [9:0] din;

  logic       vsync, hsync, done, efs, efe;
  logic [9:0] dout;
  logic [11:0] pix, line;

  logic       s_vsync, s_hsync, s_done, s_efs, s_efe;
  logic [9:0] s_dout;
  logic [3:0] s_pix, s_line;

  int checks = 0;
  int errors = 0;

  logic       h0, h1;
  logic [9:0] q0, q1;

  always #5 clk = ~clk;

  cpi_sync_gen #(
    .DATA_W(10), .CNT_W(12), .VS_WIDTH(8), .VBP(16), .DLY(2), .VS_POL(1'b1), .HS_POL(1'b1)
  ) dut (
    .pixel_clk_i(clk), .pixel_rstn_i(rst_n), .fs_i(fs), .fe_i(fe), .lv_i(lv), .data_i(din),
    .vsync_o(vsync), .hsync_o(hsync), .data_o(dout), .pix_cnt_o(pix), .line_cnt_o(line),
    .frame_done_o(done), .err_fs_o(efs), .err_fe_o(efe)
  );

  cpi_sync_gen #(
    .DATA_W(10), .CNT_W(4), .VS_WIDTH(8), .VBP(16), .DLY(2), .VS_POL(1'b1), .HS_POL(1'b1)
  ) dut_s (
    .pixel_clk_i(clk), .pixel_rstn_i(rst_n), .fs_i(fs), .fe_i(fe), .lv_i(lv), .data_i(din),
    .vsync_o(s_vsync), .hsync_o(s_hsync), .data_o(s_dout), .pix_cnt_o(s_pix), .line_cnt_o(s_line),
    .frame_done_o(s_done), .err_fs_o(s_efs), .err_fe_o(s_efe)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // gate: whether the DUT is in ACTIVE when this cycle's inputs are sampled
  task automatic step(input logic f_s, input logic f_e, input logic l_v, input logic [9:0] d,
                      input logic gate, input logic chk);
    fs = f_s; fe = f_e; lv = l_v; din = d;
    @(posedge clk); #1;
    h1 = h0; q1 = q0;
    h0 = l_v & gate;
    q0 = (l_v & gate) ? d : 10'd0;
    if (chk) begin
      check("hsync", 32'(hsync), 32'(h1));
      check("data", 32'(dout), 32'(q1));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
  endtask

  task automatic start_frame();
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    idle(24);
  endtask

  task automatic send_line(input int n, input int gap, input int base);
    for (int p = 0; p < n; p++) step(1'b0, 1'b0, 1'b1, 10'(base + p * 7), 1'b1, 1'b1);
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; fs = 1'b0; fe = 1'b0; lv = 1'b0; din = '0;
    h0 = 1'b0; h1 = 1'b0; q0 = '0; q1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vsync", 32'(vsync), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd0);
    check("rst_data", 32'(dout), 32'd0);
    check("rst_pix", 32'(pix), 32'd0);
    check("rst_line", 32'(line), 32'd0);
    check("rst_pulses", 32'({done, efs, efe}), 32'd0);
    rst_n = 1'b1;

    // fe_i with no open frame
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    check("idle_fe_err", 32'(efe), 32'd1);
    idle(1);
    check("idle_fe_err_end", 32'(efe), 32'd0);

    // Frame A: VSYNC width, line dropped in VBP, 3 lines of 640
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    check("a_no_errfs", 32'(efs), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("a_vsync_on", 32'(vsync), 32'd1);
      idle(1);
    end
    check("a_vsync_off", 32'(vsync), 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 10'(i + 5), 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
    check("a_vbp_pix", 32'(pix), 32'd0);
    for (int l = 0; l < 3; l++) begin
      send_line(640, 4, l * 101);
      check("a_pix640", 32'(pix), 32'd640);
    end
    check("a_small_sat", 32'(s_pix), 32'd15);
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b1, 1'b1);
    check("a_done", 32'(done), 32'd1);
    check("a_line3", 32'(line), 32'd3);
    check("a_no_errfe", 32'(efe), 32'd0);
    check("a_small_line3", 32'(s_line), 32'd3);
    idle(1);
    check("a_done_end", 32'(done), 32'd0);

    // Frame B: fs_i after 2 lines restarts, next frame of 1 line
    start_frame();
    send_line(50, 3, 3);
    send_line(50, 3, 9);
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
    check("b_errfs", 32'(efs), 32'd1);
    check("b_vsync_1", 32'(vsync), 32'd1);
    for (int i = 0; i < 7; i++) begin
      idle(1);
      if (i == 0) check("b_errfs_end", 32'(efs), 32'd0);
      check("b_vsync_on", 32'(vsync), 32'd1);
    end
    idle(1);
    check("b_vsync_off", 32'(vsync), 32'd0);
    idle(16);
    send_line(30, 2, 77);
    check("b_pix30", 32'(pix), 32'd30);
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b1, 1'b1);
    check("b_done", 32'(done), 32'd1);
    check("b_line1", 32'(line), 32'd1);

    // Frame C: fe_i on pixel 100 with lv_i still high
    start_frame();
    for (int p = 0; p < 99; p++) step(1'b0, 1'b0, 1'b1, 10'(p * 3), 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 10'd999, 1'b1, 1'b1);
    check("c_errfe", 32'(efe), 32'd1);
    check("c_done", 32'(done), 32'd1);
    check("c_pix100", 32'(pix), 32'd100);
    check("c_line1", 32'(line), 32'd1);
    check("c_small_pix", 32'(s_pix), 32'd15);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 10'd5, 1'b0, 1'b1);
    check("c_pix_hold", 32'(pix), 32'd100);
    check("c_pulses_end", 32'({done, efe}), 32'd0);

    // Frame D: 20-pixel line, then back-to-back fs_i+fe_i
    start_frame();
    send_line(20, 2, 40);
    check("d_pix20", 32'(pix), 32'd20);
    check("d_small_pix15", 32'(s_pix), 32'd15);
    step(1'b1, 1'b1, 1'b0, 10'd0, 1'b1, 1'b0);
    check("d_b2b_done", 32'(done), 32'd1);
    check("d_b2b_noerr", 32'({efs, efe}), 32'd0);
    check("d_b2b_vsync", 32'(vsync), 32'd1);
    check("d_b2b_line", 32'(line), 32'd1);

    // Async reset mid-VSYNC
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check("r1_vsync", 32'(vsync), 32'd0);
    check("r1_pix", 32'(pix), 32'd0);
    check("r1_line", 32'(line), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; h0 = 1'b0; h1 = 1'b0; q0 = '0; q1 = '0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("r1_no_done", 32'(done), 32'd0);
      check("r1_vsync_off", 32'(vsync), 32'd0);
    end

    // Async reset mid-line
    start_frame();
    for (int p = 0; p < 5; p++) step(1'b0, 1'b0, 1'b1, 10'(p + 200), 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("r2_hsync", 32'(hsync), 32'd0);
    check("r2_data", 32'(dout), 32'd0);
    check("r2_vsync", 32'(vsync), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; h0 = 1'b0; h1 = 1'b0; q0 = '0; q1 = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
      check("r2_no_done", 32'(done), 32'd0);
      check("r2_vsync_off", 32'(vsync), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    check("r2_idle_fe", 32'(efe), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
